// File: rtl/adder_pipe.sv
// Segmented-carry pipelined adder/subtractor; each stage resolves one CHUNK-bit slice.
// Latency STAGES cycles from accept to out_valid; one beat per cycle at full rate.
// Backpressure: collapsing valid/ready chain, holds up to STAGES beats, in_ready=0 when full.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   operand handshake (a_in, b_in, c_in, sub_in)
//   out_valid/out_ready result handshake (sum_out, c_out, ovf_out)
module adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  input  logic             sub_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum_out,
  output logic             c_out,
  output logic             ovf_out
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  // Per-stage state. r_a/r_b hold the operand bits not yet consumed, shifted so
  // the next chunk to resolve always sits at bit 0. r_s accumulates resolved
  // chunks from the top down; after the last stage chunk 0 lands at bit 0.
  logic [STAGES-1:0] r_v;
  logic [STAGES-1:0] r_cy;
  logic [STAGES-1:0] r_am;
  logic [STAGES-1:0] r_bm;
  logic [WIDTH-1:0]  r_a [STAGES];
  logic [WIDTH-1:0]  r_b [STAGES];
  logic [WIDTH-1:0]  r_s [STAGES];

  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_src_v;
  logic [STAGES-1:0] w_src_c;
  logic [STAGES-1:0] w_src_am;
  logic [STAGES-1:0] w_src_bm;
  logic [STAGES-1:0] w_ncy;
  logic [WIDTH-1:0]  w_src_a [STAGES];
  logic [WIDTH-1:0]  w_src_b [STAGES];
  logic [WIDTH-1:0]  w_src_s [STAGES];
  logic [WIDTH-1:0]  w_nsum  [STAGES];
  logic [WIDTH-1:0]  w_b_eff;
  logic              w_c_eff;
  logic [CHUNK:0]    w_chunk;

  always_comb begin
    w_b_eff = sub_in ? ~b_in : b_in;
    w_c_eff = c_in ^ sub_in;

    // A stage may load when any stage at or after it is empty, or when the
    // output is being drained. This is the unrolled form of the chain
    // adv[k] = !v[k] || adv[k+1], adv[last] = !v[last] || out_ready.
    w_adv = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_adv[k] = out_ready;
      for (int j = k; j < STAGES; j++) begin
        if (!r_v[j]) w_adv[k] = 1'b1;
      end
    end

    // Stage 0 takes the raw operands; later stages take the previous stage.
    w_src_v[0]  = in_valid;
    w_src_a[0]  = a_in;
    w_src_b[0]  = w_b_eff;
    w_src_s[0]  = '0;
    w_src_c[0]  = w_c_eff;
    w_src_am[0] = a_in[WIDTH-1];
    w_src_bm[0] = w_b_eff[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      w_src_v[k]  = r_v[k-1];
      w_src_a[k]  = r_a[k-1];
      w_src_b[k]  = r_b[k-1];
      w_src_s[k]  = r_s[k-1];
      w_src_c[k]  = r_cy[k-1];
      w_src_am[k] = r_am[k-1];
      w_src_bm[k] = r_bm[k-1];
    end

    w_chunk = '0;
    w_ncy   = '0;
    for (int k = 0; k < STAGES; k++) begin
      w_chunk = {1'b0, w_src_a[k][CHUNK-1:0]} + {1'b0, w_src_b[k][CHUNK-1:0]}
              + (CHUNK+1)'(w_src_c[k]);
      w_nsum[k] = (w_src_s[k] >> CHUNK)
                | (WIDTH'(w_chunk[CHUNK-1:0]) << (WIDTH - CHUNK));
      w_ncy[k]  = w_chunk[CHUNK];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v  <= '0;
      r_cy <= '0;
      r_am <= '0;
      r_bm <= '0;
      for (int k = 0; k < STAGES; k++) begin
        r_a[k] <= '0;
        r_b[k] <= '0;
        r_s[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_v[k] <= w_src_v[k];
          // Data only moves with a valid beat so the output registers keep
          // the last real result instead of picking up bubble contents.
          if (w_src_v[k]) begin
            r_a[k]  <= w_src_a[k] >> CHUNK;
            r_b[k]  <= w_src_b[k] >> CHUNK;
            r_s[k]  <= w_nsum[k];
            r_cy[k] <= w_ncy[k];
            r_am[k] <= w_src_am[k];
            r_bm[k] <= w_src_bm[k];
          end
        end
      end
    end
  end

  assign in_ready  = w_adv[0];
  assign out_valid = r_v[LAST];
  assign sum_out   = r_s[LAST];
  assign c_out     = r_cy[LAST];
  // Signed overflow: operands agree in sign but the result does not.
  assign ovf_out   = (r_am[LAST] == r_bm[LAST]) && (r_s[LAST][WIDTH-1] != r_am[LAST]);

endmodule

// File: tb/tb_adder_pipe.sv
// Bench for adder_pipe: directed vectors, random streaming and backpressure on a 32/4 instance,
// plus random sweeps on 8/1, 16/2 and 64/8 instances, all against a behavioural model.
// Outputs are sampled on the falling edge; inputs are driven 1 time unit after the rising edge.
module tb_adder_pipe;

  typedef struct {
    logic [63:0] sum;
    logic        c;
    logic        ovf;
    int          cyc;
    bit          strict;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  int   cyc    = 0;
  logic clk    = 1'b0;
  logic rst    = 1'b1;
  logic sw_rst = 1'b1;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Behavioural model: unsigned arithmetic for sum/carry, true signed
  // arithmetic with a range test for overflow.
  function automatic exp_t ref_res(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic c, input logic sub);
    logic        [71:0] ua, ub, uc, r;
    logic signed [71:0] sa, sb, sc, sr, smax, smin;
    exp_t e;
    ua = {8'd0, a};
    ub = {8'd0, b};
    uc = {71'd0, c};
    if (sub) begin
      e.c = (ua >= ub + uc);
      r   = ua - ub - uc;
    end else begin
      r   = ua + ub + uc;
      e.c = r[w];
    end
    e.sum = r[63:0] & ((64'd1 << w) - 64'd1);
    sa   = $signed(ua << (72 - w)) >>> (72 - w);
    sb   = $signed(ub << (72 - w)) >>> (72 - w);
    sc   = $signed(uc);
    sr   = sub ? (sa - sb - sc) : (sa + sb + sc);
    smax = (72'sd1 <<< (w - 1)) - 72'sd1;
    smin = -(72'sd1 <<< (w - 1));
    e.ovf    = (sr > smax) || (sr < smin);
    e.cyc    = 0;
    e.strict = 0;
    return e;
  endfunction

  // ---------------- main 32/4 instance ----------------
  logic        in_valid, in_ready, c_in, sub_in, out_valid, out_ready, c_out, ovf_out;
  logic [31:0] a_in, b_in, sum_out;

  adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .sub_in(sub_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum_out(sum_out), .c_out(c_out), .ovf_out(ovf_out)
  );

  exp_t        mq[$];
  exp_t        m_e;
  bit          m_strict = 0;
  bit          m_prev_stall = 0;
  logic [31:0] m_held_sum;
  logic [2:0]  m_held_flg;
  int          m_acc = 0;

  always @(negedge clk) begin
    if (rst) begin
      mq.delete();
      m_prev_stall = 0;
    end else begin
      if (m_prev_stall) begin
        chk("hold_sum", 64'(sum_out), 64'(m_held_sum));
        chk("hold_flags", 64'({out_valid, c_out, ovf_out}), 64'(m_held_flg));
      end
      if (out_valid && out_ready) begin
        if (mq.size() == 0) chk("spurious_out", 64'(out_valid), 64'd0);
        else begin
          m_e = mq.pop_front();
          chk("sum", 64'(sum_out), m_e.sum);
          chk("c_out", 64'(c_out), 64'(m_e.c));
          chk("ovf", 64'(ovf_out), 64'(m_e.ovf));
          if (m_e.strict) chk("latency", 64'(cyc - m_e.cyc), 64'd4);
        end
      end
      if (in_valid && in_ready) begin
        m_e        = ref_res(32, 64'(a_in), 64'(b_in), c_in, sub_in);
        m_e.cyc    = cyc;
        m_e.strict = m_strict;
        mq.push_back(m_e);
        m_acc++;
      end
      m_prev_stall = out_valid && !out_ready;
      m_held_sum   = sum_out;
      m_held_flg   = {out_valid, c_out, ovf_out};
    end
  end

  task automatic rand_beat();
    a_in   = $urandom;
    b_in   = $urandom;
    c_in   = 1'($urandom_range(0, 1));
    sub_in = 1'($urandom_range(0, 1));
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60 && mq.size() != 0; i++) @(negedge clk);
    chk(nm, 64'(mq.size()), 64'd0);
  endtask

  task automatic directed(input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic s, input logic [31:0] xs, input logic xc,
                          input logic xo, input string nm);
    int n;
    @(posedge clk); #1;
    a_in = a; b_in = b; c_in = c; sub_in = s; in_valid = 1'b1;
    @(negedge clk);
    chk({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 20);
    chk({nm, "_latency"}, 64'(n), 64'd4);
    chk({nm, "_sum"}, 64'(sum_out), 64'(xs));
    chk({nm, "_c_out"}, 64'(c_out), 64'(xc));
    chk({nm, "_ovf"}, 64'(ovf_out), 64'(xo));
  endtask

  // ---------------- parameter sweep instances ----------------
  for (genvar g = 0; g < 3; g++) begin : gen_sw
    localparam int W = (g == 0) ? 8 : (g == 1) ? 16 : 64;
    localparam int S = (g == 0) ? 1 : (g == 1) ? 2  : 8;

    logic         s_iv, s_ir, s_c, s_sub, s_ov, s_or, s_co, s_of;
    logic         s_done = 1'b0;
    logic [W-1:0] s_a, s_b, s_sum, s_held_sum;
    logic [2:0]   s_held_flg;
    exp_t         q[$];
    exp_t         se;
    bit           s_strict = 0;
    bit           s_prev = 0;
    bit           s_take;

    adder_pipe #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk(clk), .rst(sw_rst),
      .in_valid(s_iv), .in_ready(s_ir),
      .a_in(s_a), .b_in(s_b), .c_in(s_c), .sub_in(s_sub),
      .out_valid(s_ov), .out_ready(s_or),
      .sum_out(s_sum), .c_out(s_co), .ovf_out(s_of)
    );

    always @(negedge clk) begin
      if (sw_rst) begin
        q.delete();
        s_prev = 0;
      end else begin
        if (s_prev) begin
          chk($sformatf("sw%0d_hold_sum", W), 64'(s_sum), 64'(s_held_sum));
          chk($sformatf("sw%0d_hold_flags", W), 64'({s_ov, s_co, s_of}), 64'(s_held_flg));
        end
        if (s_ov && s_or) begin
          if (q.size() == 0) chk($sformatf("sw%0d_spurious", W), 64'(s_ov), 64'd0);
          else begin
            se = q.pop_front();
            chk($sformatf("sw%0d_sum", W), 64'(s_sum), se.sum);
            chk($sformatf("sw%0d_c_out", W), 64'(s_co), 64'(se.c));
            chk($sformatf("sw%0d_ovf", W), 64'(s_of), 64'(se.ovf));
            if (se.strict) chk($sformatf("sw%0d_latency", W), 64'(cyc - se.cyc), 64'(S));
          end
        end
        if (s_iv && s_ir) begin
          se        = ref_res(W, 64'(s_a), 64'(s_b), s_c, s_sub);
          se.cyc    = cyc;
          se.strict = s_strict;
          q.push_back(se);
        end
        s_prev     = s_ov && !s_or;
        s_held_sum = s_sum;
        s_held_flg = {s_ov, s_co, s_of};
      end
    end

    task automatic sw_rand();
      s_a   = W'({$urandom, $urandom});
      s_b   = W'({$urandom, $urandom});
      s_c   = 1'($urandom_range(0, 1));
      s_sub = 1'($urandom_range(0, 1));
    endtask

    initial begin
      s_iv = 1'b0; s_or = 1'b0;
      sw_rand();
      wait (!sw_rst);
      @(posedge clk); #1;
      for (int i = 0; i < 400; i++) begin
        @(negedge clk);
        s_take = s_iv && s_ir;
        @(posedge clk); #1;
        if (s_take || !s_iv) begin
          s_iv = ($urandom_range(0, 3) != 0);
          sw_rand();
        end
        s_or = 1'($urandom_range(0, 1));
      end
      s_or = 1'b1;
      @(negedge clk);
      @(posedge clk); #1;
      s_iv = 1'b0;
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      chk($sformatf("sw%0d_drain_random", W), 64'(q.size()), 64'd0);
      s_strict = 1;
      @(posedge clk); #1;
      for (int i = 0; i < 40; i++) begin
        sw_rand();
        s_iv = 1'b1;
        @(posedge clk); #1;
      end
      s_iv = 1'b0;
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      chk($sformatf("sw%0d_drain_stream", W), 64'(q.size()), 64'd0);
      s_strict = 0;
      s_done   = 1'b1;
    end
  end

  // ---------------- main sequence ----------------
  exp_t pe;
  int   a0;
  bit   take;

  initial begin
    in_valid = 1'b0; out_ready = 1'b0;
    a_in = '0; b_in = '0; c_in = 1'b0; sub_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum_out), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    chk("rst_ovf", 64'(ovf_out), 64'd0);
    rst = 1'b0;
    sw_rst = 1'b0;
    @(negedge clk);
    chk("idle_in_ready", 64'(in_ready), 64'd1);
    chk("idle_out_valid", 64'(out_valid), 64'd0);
    chk("idle_sum", 64'(sum_out), 64'd0);

    // Hand-computed values pinning the model.
    pe = ref_res(32, 64'hFFFF_FFFF, 64'h0, 1'b1, 1'b0);
    chk("model_ripple", 64'({pe.ovf, pe.c, pe.sum[31:0]}), 64'h1_0000_0000);
    pe = ref_res(32, 64'h8000_0000, 64'h1, 1'b0, 1'b1);
    chk("model_sub_ovf", 64'({pe.ovf, pe.c, pe.sum[31:0]}), 64'h3_7FFF_FFFF);
    pe = ref_res(32, 64'd5, 64'd7, 1'b0, 1'b1);
    chk("model_sub_neg", 64'({pe.ovf, pe.c, pe.sum[31:0]}), 64'h0_FFFF_FFFE);
    pe = ref_res(8, 64'h7F, 64'h01, 1'b0, 1'b0);
    chk("model_add8_ovf", 64'({pe.ovf, pe.c, pe.sum[7:0]}), 64'h2_80);

    out_ready = 1'b1;
    m_strict  = 1;
    directed(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "ripple");
    directed(32'h8000_0000, 32'h1, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_ovf");
    directed(32'd5, 32'd7, 1'b0, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_neg");
    drain("drain_directed");

    // 100 back-to-back beats at full rate.
    a0 = m_acc;
    @(posedge clk); #1;
    for (int i = 0; i < 100; i++) begin
      rand_beat();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("stream_accepts", 64'(m_acc - a0), 64'd100);
    drain("drain_stream");
    m_strict = 0;

    // Output stalled: the pipeline must fill with exactly 4 beats.
    @(posedge clk); #1;
    out_ready = 1'b0;
    a0 = m_acc;
    rand_beat();
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      take = in_ready;
      @(posedge clk); #1;
      if (take) rand_beat();
    end
    chk("bp_accepts", 64'(m_acc - a0), 64'd4);
    @(negedge clk);
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_out_valid", 64'(out_valid), 64'd1);

    // Random out_ready with a source that holds unaccepted beats.
    @(posedge clk); #1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk); #1;
      if (take || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_beat();
      end
      out_ready = 1'($urandom_range(0, 1));
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("drain_random");

    // Reset between edges with 3 beats in flight.
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_beat();
      in_valid = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_out_valid", 64'(out_valid), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", 64'(out_valid), 64'd0);
    chk("async_rst_sum", 64'(sum_out), 64'd0);
    chk("async_rst_c_out", 64'(c_out), 64'd0);
    chk("async_rst_ovf", 64'(ovf_out), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      chk("post_rst_no_stale", 64'(out_valid), 64'd0);
    end

    for (int i = 0; i < 20000 && !(gen_sw[0].s_done && gen_sw[1].s_done && gen_sw[2].s_done); i++)
      @(posedge clk);
    chk("sweep8_done", 64'(gen_sw[0].s_done), 64'd1);
    chk("sweep16_done", 64'(gen_sw[1].s_done), 64'd1);
    chk("sweep64_done", 64'(gen_sw[2].s_done), 64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
